// File: rtl/rv32_pkg.sv
// Shared RV32I encoding definitions: format codes, major opcodes,
// NOP word, field bundle and an immediate range helper.
package rv32_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } fields_t;

  // True when v[31:msb] are all equal, i.e. v is a sign extension
  // of its low msb+1 bits.
  function automatic logic sext_fits(
    input logic [31:0] v,
    input logic [4:0]  msb
  );
    logic [31:0] t;
    t = 32'($signed(v) >>> msb);
    return (t == '0) || (t == '1);
  endfunction

endpackage

// File: rtl/instr_field_pack.sv
// Combinational RV32I legality check and bit packing.
// Ports: f (field bundle) in; instr (word or NOP), illegal out.
module instr_field_pack
  import rv32_pkg::*;
(
  input  fields_t     f,
  output logic [31:0] instr,
  output logic        illegal
);

  logic        is_r, is_i, is_s;
  logic        is_b, is_u, is_j;
  logic        shift, f3_alt;
  logic        fit11, fit12, fit20;
  logic        legal;
  logic [31:0] word;

  assign is_r = f.fmt == FMT_R;
  assign is_i = f.fmt == FMT_I;
  assign is_s = f.fmt == FMT_S;
  assign is_b = f.fmt == FMT_B;
  assign is_u = f.fmt == FMT_U;
  assign is_j = f.fmt == FMT_J;

  assign shift = (f.opcode == OP_IMM) &&
                 (f.func3 == 3'b001 ||
                  f.func3 == 3'b101);
  assign f3_alt = f.func3 == 3'b101;

  assign fit11 = sext_fits(f.imm, 5'd11);
  assign fit12 = sext_fits(f.imm, 5'd12);
  assign fit20 = sext_fits(f.imm, 5'd20);

  always_comb begin
    legal = 1'b0;
    word  = '0;
    unique case (1'b1)
      is_r: begin
        legal = (f.opcode == OP_OP) &&
                ((f.func7 == F7_ZERO) ||
                 (f.func7 == F7_ALT &&
                  (f.func3 == 3'b000 || f3_alt)));
        word = {f.func7, f.rs2, f.rs1,
                f.func3, f.rd, f.opcode};
      end
      is_i: begin
        if (shift) begin
          legal = (f.imm[31:5] == '0) &&
                  ((f.func7 == F7_ZERO) ||
                   (f.func7 == F7_ALT && f3_alt));
          word = {f.func7, f.imm[4:0], f.rs1,
                  f.func3, f.rd, f.opcode};
        end else begin
          if (f.opcode == OP_IMM)
            legal = fit11;
          else if (f.opcode == OP_LOAD)
            legal = fit11 && (f.func3 inside
                    {3'b000, 3'b001, 3'b010,
                     3'b100, 3'b101});
          else if (f.opcode == OP_JALR)
            legal = fit11 && f.func3 == 3'b000;
          word = {f.imm[11:0], f.rs1,
                  f.func3, f.rd, f.opcode};
        end
      end
      is_s: begin
        legal = (f.opcode == OP_STORE) &&
                (f.func3 <= 3'b010) && fit11;
        word = {f.imm[11:5], f.rs2, f.rs1,
                f.func3, f.imm[4:0], f.opcode};
      end
      is_b: begin
        legal = (f.opcode == OP_BRANCH) &&
                (f.func3 != 3'b010) &&
                (f.func3 != 3'b011) &&
                fit12 && !f.imm[0];
        word = {f.imm[12], f.imm[10:5], f.rs2,
                f.rs1, f.func3, f.imm[4:1],
                f.imm[11], f.opcode};
      end
      is_u: begin
        legal = (f.opcode == OP_LUI ||
                 f.opcode == OP_AUIPC) &&
                (f.imm[11:0] == '0);
        word = {f.imm[31:12], f.rd, f.opcode};
      end
      is_j: begin
        legal = (f.opcode == OP_JAL) &&
                fit20 && !f.imm[0];
        word = {f.imm[20], f.imm[10:1], f.imm[11],
                f.imm[19:12], f.rd, f.opcode};
      end
      default: legal = 1'b0;
    endcase
  end

  assign instr   = legal ? word : NOP_WORD;
  assign illegal = ~legal;

endmodule

// File: rtl/instr_encoder.sv
// Two-stage valid/ready RV32I encoder: S1 holds fields, S2 holds word,
// address and illegal flag. Ports: field bundle in, encoded word out.
module instr_encoder
  import rv32_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 256
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [2:0]  FMT,
  input  logic [6:0]  OPCODE,
  input  logic [2:0]  FUNC3,
  input  logic [6:0]  FUNC7,
  input  logic [4:0]  RD,
  input  logic [4:0]  RS1,
  input  logic [4:0]  RS2,
  input  logic [31:0] IMM,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [31:0] INSTR,
  output logic [31:0] INSTR_ADDR,
  output logic        ILLEGAL,
  output logic [7:0]  ERR_COUNT
);

  localparam logic [31:0] LAST_ADDR =
    BASE_ADDR + 32'(4 * (DEPTH_WORDS - 1));

  fields_t     in_f;
  fields_t     s1_f;
  logic        s1_valid;
  logic        s2_valid;
  logic        s2_free;
  logic        s1_move;
  logic        accept;
  logic        out_fire;
  logic [31:0] pk_instr;
  logic        pk_illegal;
  logic [31:0] instr_q;
  logic [31:0] addr_q;
  logic        illegal_q;
  logic [7:0]  err_q;

  always_comb begin
    in_f        = '0;
    in_f.fmt    = FMT;
    in_f.opcode = OPCODE;
    in_f.func3  = FUNC3;
    in_f.func7  = FUNC7;
    in_f.rd     = RD;
    in_f.rs1    = RS1;
    in_f.rs2    = RS2;
    in_f.imm    = IMM;
  end

  assign s2_free  = ~s2_valid | OUT_READY;
  assign s1_move  = s1_valid & s2_free;
  // Held low during reset so nothing is taken in that window.
  assign IN_READY = RESET_N & (~s1_valid | s2_free);
  assign accept   = IN_VALID & IN_READY;
  assign out_fire = s2_valid & OUT_READY;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      s1_valid <= 1'b0;
      s1_f     <= '0;
    end else begin
      if (~s1_valid | s2_free)
        s1_valid <= IN_VALID;
      if (accept)
        s1_f <= in_f;
    end
  end

  instr_field_pack u_pack (
    .f       (s1_f),
    .instr   (pk_instr),
    .illegal (pk_illegal)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      s2_valid  <= 1'b0;
      instr_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      if (s2_free)
        s2_valid <= s1_valid;
      if (s1_move) begin
        instr_q   <= pk_instr;
        illegal_q <= pk_illegal;
      end
    end
  end

  // Address is bound at output, so it always follows output order.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      addr_q <= BASE_ADDR;
      err_q  <= '0;
    end else if (out_fire) begin
      addr_q <= (addr_q == LAST_ADDR) ?
                BASE_ADDR : addr_q + 32'd4;
      if (illegal_q && err_q != 8'hFF)
        err_q <= err_q + 8'd1;
    end
  end

  assign OUT_VALID  = s2_valid;
  assign INSTR      = instr_q;
  assign INSTR_ADDR = addr_q;
  assign ILLEGAL    = illegal_q;
  assign ERR_COUNT  = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Testbench for instr_encoder: directed vectors, stall, reset and
// randomized stream against a field-arithmetic reference model.
module tb_instr_encoder;

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } bundle_t;

  typedef struct {
    bundle_t     b;
    logic [31:0] w;
    bit          ill;
  } vec_t;

  typedef struct {
    logic [31:0] w;
    bit          ill;
    int          in_cyc;
  } exp_t;

  typedef struct {
    logic [31:0] w;
    bit          ill;
    logic [31:0] addr;
    logic [31:0] waddr;
    logic [7:0]  err;
    int          cyc;
    int          in_cyc;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [2:0]  fmt;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic [6:0]  func7;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm;
  logic        out_valid, out_ready;
  logic [31:0] instr, instr_addr;
  logic        illegal;
  logic [7:0]  err_count;
  logic        w_in_ready, w_out_valid, w_ill;
  logic [31:0] w_instr, w_addr;
  logic [7:0]  w_err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int out_cnt  = 0;
  int m_err    = 0;

  exp_t exp_q[$];
  obs_t obs[$];
  vec_t vt[8];

  bit          stall_prev = 0;
  logic [31:0] p_instr, p_addr;
  logic        p_ill;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  instr_encoder u_dut (
    .CLK(clk), .RESET_N(rst_n),
    .IN_VALID(in_valid), .IN_READY(in_ready),
    .FMT(fmt), .OPCODE(opcode),
    .FUNC3(func3), .FUNC7(func7),
    .RD(rd), .RS1(rs1), .RS2(rs2), .IMM(imm),
    .OUT_VALID(out_valid), .OUT_READY(out_ready),
    .INSTR(instr), .INSTR_ADDR(instr_addr),
    .ILLEGAL(illegal), .ERR_COUNT(err_count)
  );

  instr_encoder #(
    .BASE_ADDR(32'h0), .DEPTH_WORDS(4)
  ) u_wrap (
    .CLK(clk), .RESET_N(rst_n),
    .IN_VALID(in_valid), .IN_READY(w_in_ready),
    .FMT(fmt), .OPCODE(opcode),
    .FUNC3(func3), .FUNC7(func7),
    .RD(rd), .RS1(rs1), .RS2(rs2), .IMM(imm),
    .OUT_VALID(w_out_valid), .OUT_READY(out_ready),
    .INSTR(w_instr), .INSTR_ADDR(w_addr),
    .ILLEGAL(w_ill), .ERR_COUNT(w_err)
  );

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  // Reference: legality from numeric ranges, word from shifted fields.
  function automatic void ref_model(input bundle_t b,
                                    output logic [31:0] w,
                                    output bit ill);
    int s;
    logic [31:0] u, op, rdv, r1, r2, f3, f7, enc;
    bit ok, sh;
    s   = int'($signed(b.imm));
    u   = b.imm;
    op  = 32'(b.op);
    rdv = 32'(b.rd);
    r1  = 32'(b.rs1);
    r2  = 32'(b.rs2);
    f3  = 32'(b.f3);
    f7  = 32'(b.f7);
    sh  = (b.op == 7'h13) &&
          (b.f3 == 3'd1 || b.f3 == 3'd5);
    ok  = 0;
    enc = 0;
    case (b.fmt)
      3'd0: begin
        ok = (b.op == 7'h33) &&
             (b.f7 == 7'h00 ||
              (b.f7 == 7'h20 &&
               (b.f3 == 3'd0 || b.f3 == 3'd5)));
        enc = (f7 << 25) | (r2 << 20) | (r1 << 15) |
              (f3 << 12) | (rdv << 7) | op;
      end
      3'd1: begin
        if (sh) begin
          ok = (u < 32) &&
               (b.f7 == 7'h00 ||
                (b.f7 == 7'h20 && b.f3 == 3'd5));
          enc = (f7 << 25) | ((u & 32'd31) << 20);
        end else begin
          ok = (s >= -2048) && (s <= 2047) &&
               ((b.op == 7'h13) ||
                (b.op == 7'h03 &&
                 (b.f3 inside {3'd0, 3'd1, 3'd2,
                               3'd4, 3'd5})) ||
                (b.op == 7'h67 && b.f3 == 3'd0));
          enc = (u & 32'hfff) << 20;
        end
        enc = enc | (r1 << 15) | (f3 << 12) |
              (rdv << 7) | op;
      end
      3'd2: begin
        ok = (b.op == 7'h23) && (b.f3 <= 3'd2) &&
             (s >= -2048) && (s <= 2047);
        enc = (((u >> 5) & 32'h7f) << 25) |
              (r2 << 20) | (r1 << 15) | (f3 << 12) |
              ((u & 32'd31) << 7) | op;
      end
      3'd3: begin
        ok = (b.op == 7'h63) &&
             (b.f3 != 3'd2) && (b.f3 != 3'd3) &&
             (s >= -4096) && (s <= 4095) &&
             (s % 2 == 0);
        enc = (((u >> 12) & 32'd1) << 31) |
              (((u >> 5) & 32'h3f) << 25) |
              (r2 << 20) | (r1 << 15) | (f3 << 12) |
              (((u >> 1) & 32'hf) << 8) |
              (((u >> 11) & 32'd1) << 7) | op;
      end
      3'd4: begin
        ok = (b.op == 7'h37 || b.op == 7'h17) &&
             ((u & 32'hfff) == 0);
        enc = (u & 32'hffff_f000) | (rdv << 7) | op;
      end
      3'd5: begin
        ok = (b.op == 7'h6f) &&
             (s >= -1048576) && (s <= 1048575) &&
             (s % 2 == 0);
        enc = (((u >> 20) & 32'd1) << 31) |
              (((u >> 1) & 32'h3ff) << 21) |
              (((u >> 11) & 32'd1) << 20) |
              (((u >> 12) & 32'hff) << 12) |
              (rdv << 7) | op;
      end
      default: ok = 0;
    endcase
    ill = !ok;
    w   = ok ? enc : 32'h0000_0013;
  endfunction

  function automatic vec_t mk(
    input logic [2:0] f, input logic [6:0] o,
    input logic [2:0] c3, input logic [6:0] c7,
    input logic [4:0] d, input logic [4:0] a,
    input logic [4:0] b2, input logic [31:0] im,
    input logic [31:0] w, input bit il);
    vec_t v;
    v.b = '{fmt:f, op:o, f3:c3, f7:c7,
            rd:d, rs1:a, rs2:b2, imm:im};
    v.w   = w;
    v.ill = il;
    return v;
  endfunction

  function automatic bundle_t rand_bundle();
    bundle_t b;
    b.fmt = ($urandom_range(0, 9) == 0) ?
            3'($urandom_range(6, 7)) :
            3'($urandom_range(0, 5));
    case (b.fmt)
      3'd0: b.op = 7'h33;
      3'd1: case ($urandom_range(0, 2))
              0: b.op = 7'h03;
              1: b.op = 7'h13;
              default: b.op = 7'h67;
            endcase
      3'd2: b.op = 7'h23;
      3'd3: b.op = 7'h63;
      3'd4: b.op = $urandom_range(0, 1) ? 7'h37 : 7'h17;
      default: b.op = 7'h6f;
    endcase
    if ($urandom_range(0, 6) == 0)
      b.op = 7'($urandom());
    b.f3 = 3'($urandom());
    case ($urandom_range(0, 3))
      0, 1: b.f7 = 7'h00;
      2: b.f7 = 7'h20;
      default: b.f7 = 7'($urandom());
    endcase
    b.rd  = 5'($urandom());
    b.rs1 = 5'($urandom());
    b.rs2 = 5'($urandom());
    case ($urandom_range(0, 5))
      0: b.imm = 32'($urandom_range(0, 8191)) - 32'd4096;
      1: b.imm = (32'($urandom_range(0, 8191)) -
                  32'd4096) & ~32'd1;
      2: b.imm = $urandom();
      3: b.imm = $urandom() & 32'hffff_f000;
      4: b.imm = 32'($urandom_range(0, 40));
      default: b.imm = (32'($urandom_range(0, 2097151)) -
                        32'd1048576) & ~32'd1;
    endcase
    return b;
  endfunction

  // Scoreboard and output monitor, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    logic [31:0] ew;
    bit eil;
    if (!rst_n) begin
      stall_prev = 0;
    end else begin
      if (stall_prev) begin
        check("hold_word", {instr, instr_addr},
              {p_instr, p_addr});
        check("hold_flags", 64'({out_valid, illegal}),
              64'({1'b1, p_ill}));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL extra_word: got %h expected none",
                   instr);
        end else begin
          e = exp_q.pop_front();
          check("instr", 64'(instr), 64'(e.w));
          check("illegal", 64'(illegal), 64'(e.ill));
          check("addr", 64'(instr_addr),
                64'((out_cnt % 256) * 4));
          check("wrap_addr", 64'(w_addr),
                64'((out_cnt % 4) * 4));
          check("err_count", 64'(err_count), 64'(m_err));
          check("wrap_mirror",
                {w_instr, w_in_ready, w_out_valid,
                 w_ill, w_err, 21'd0},
                {instr, in_ready, out_valid,
                 illegal, err_count, 21'd0});
          obs.push_back('{w:instr, ill:illegal,
                          addr:instr_addr, waddr:w_addr,
                          err:err_count, cyc:cyc,
                          in_cyc:e.in_cyc});
          out_cnt++;
          if (e.ill && m_err < 255) m_err++;
        end
      end
      if (in_valid && in_ready) begin
        ref_model('{fmt:fmt, op:opcode, f3:func3,
                    f7:func7, rd:rd, rs1:rs1, rs2:rs2,
                    imm:imm}, ew, eil);
        exp_q.push_back('{w:ew, ill:eil, in_cyc:cyc});
      end
      stall_prev = out_valid && !out_ready;
      p_instr = instr;
      p_addr  = instr_addr;
      p_ill   = illegal;
    end
  end

  task automatic send(input bundle_t b);
    in_valid = 1'b1;
    fmt    = b.fmt;
    opcode = b.op;
    func3  = b.f3;
    func7  = b.f7;
    rd     = b.rd;
    rs1    = b.rs1;
    rs2    = b.rs2;
    imm    = b.imm;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
    end
    n_checks++;
    n_fail++;
    $display("FAIL send_timeout: got in_ready=0 expected 1");
    in_valid = 1'b0;
  endtask

  task automatic wait_obs(input int n);
    for (int i = 0; i < 200; i++) begin
      if (obs.size() >= n) return;
      @(negedge clk);
      #1;
    end
    n_checks++;
    n_fail++;
    $display("FAIL wait_obs: got %0d words expected %0d",
             obs.size(), n);
  endtask

  task automatic drain();
    for (int i = 0; i < 3000; i++) begin
      if (exp_q.size() == 0) begin
        repeat (3) @(posedge clk);
        #1;
        return;
      end
      @(posedge clk);
      #1;
    end
    n_checks++;
    n_fail++;
    $display("FAIL drain: got %0d pending expected 0",
             exp_q.size());
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    out_cnt = 0;
    m_err   = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw_block;
    bit done;
    vt[0] = mk(1, 7'h13, 0, 7'h00, 1, 0, 0, 32'd5,
               32'h00500093, 0);
    vt[1] = mk(0, 7'h33, 0, 7'h20, 3, 1, 2, 32'd0,
               32'h402081B3, 0);
    vt[2] = mk(2, 7'h23, 2, 7'h00, 0, 1, 2, 32'd8,
               32'h0020A423, 0);
    vt[3] = mk(3, 7'h63, 0, 7'h00, 0, 1, 2, 32'd8,
               32'h00208463, 0);
    vt[4] = mk(5, 7'h6f, 0, 7'h00, 1, 0, 0, 32'd16,
               32'h010000EF, 0);
    vt[5] = mk(4, 7'h37, 0, 7'h00, 5, 0, 0, 32'h12345000,
               32'h123452B7, 0);
    vt[6] = mk(3, 7'h63, 0, 7'h00, 0, 1, 2, 32'd3,
               32'h00000013, 1);
    vt[7] = mk(2, 7'h23, 3, 7'h00, 0, 1, 2, 32'd0,
               32'h00000013, 1);

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    fmt = '0; opcode = '0; func3 = '0; func7 = '0;
    rd = '0; rs1 = '0; rs2 = '0; imm = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_instr", 64'(instr), 64'd0);
    check("rst_addr", 64'(instr_addr), 64'd0);
    check("rst_err", 64'({illegal, err_count}), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 64'(in_ready), 64'd1);

    // Single ADDI, latency.
    obs.delete();
    @(posedge clk);
    #1;
    send(vt[0].b);
    wait_obs(1);
    if (obs.size() >= 1) begin
      check("addi_word", 64'(obs[0].w), 64'(vt[0].w));
      check("addi_ill", 64'(obs[0].ill), 64'(vt[0].ill));
      check("addi_latency",
            64'(obs[0].cyc - obs[0].in_cyc), 64'd2);
    end

    // Back-to-back stream; wrap instance sees depth 4.
    do_reset();
    obs.delete();
    for (int i = 1; i <= 5; i++) send(vt[i].b);
    wait_obs(5);
    for (int i = 0; i < 5 && i < obs.size(); i++) begin
      check("stream_word", 64'(obs[i].w), 64'(vt[i+1].w));
      check("stream_addr", 64'(obs[i].addr), 64'(4 * i));
      check("wrap_seq", 64'(obs[i].waddr),
            64'((i % 4) * 4));
      if (i > 0)
        check("stream_rate",
              64'(obs[i].cyc - obs[i-1].cyc), 64'd1);
    end

    // Illegal bundles.
    drain();
    do_reset();
    obs.delete();
    send(vt[6].b);
    send(vt[7].b);
    wait_obs(2);
    for (int i = 0; i < 2 && i < obs.size(); i++) begin
      check("illegal_word", 64'(obs[i].w), 64'(vt[6+i].w));
      check("illegal_flag", 64'(obs[i].ill), 64'(vt[6+i].ill));
    end
    @(negedge clk);
    check("err_after_two", 64'(err_count), 64'd2);

    // Stall mid-stream.
    drain();
    do_reset();
    obs.delete();
    saw_block = 0;
    fork
      for (int i = 1; i <= 5; i++) send(vt[i].b);
      begin
        repeat (2) begin
          @(posedge clk);
          #1;
        end
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          if (!in_ready) saw_block = 1;
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_obs(5);
    check("stall_blocks_input", 64'(saw_block), 64'd1);
    for (int i = 0; i < 5 && i < obs.size(); i++)
      check("stall_word", 64'(obs[i].w), 64'(vt[i+1].w));
    drain();
    check("stall_count", 64'(obs.size()), 64'd5);

    // Error counter saturation.
    do_reset();
    for (int i = 0; i < 260; i++)
      send('{fmt:3'd7, op:7'h13, f3:3'd0, f7:7'd0,
             rd:5'd0, rs1:5'd0, rs2:5'd0, imm:32'd0});
    drain();
    check("err_saturate", 64'(err_count), 64'd255);

    // Random stream with random back-pressure.
    do_reset();
    done = 0;
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          send(rand_bundle());
        end
        done = 1;
      end
      while (!done) begin
        @(posedge clk);
        #1;
        out_ready = ($urandom_range(0, 3) != 0);
      end
    join
    out_ready = 1'b1;
    drain();

    // Reset while both stages hold words.
    out_ready = 1'b0;
    send(vt[1].b);
    send(vt[2].b);
    @(negedge clk);
    check("full_before_rst",
          64'({out_valid, in_ready}), 64'({1'b1, 1'b0}));
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_async_valid", 64'(out_valid), 64'd0);
    check("rst_async_ready", 64'(in_ready), 64'd0);
    exp_q.delete();
    out_cnt = 0;
    m_err   = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    obs.delete();
    send(vt[0].b);
    wait_obs(1);
    if (obs.size() >= 1) begin
      check("after_rst_addr", 64'(obs[0].addr), 64'd0);
      check("after_rst_err", 64'(obs[0].err), 64'd0);
      check("after_rst_word", 64'(obs[0].w), 64'(vt[0].w));
    end
    drain();
    check("after_rst_count", 64'(obs.size()), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
